// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_SB_TICK    = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input; flops reset to RESET_VAL.
module rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg[0] <= RESET_VAL;
        end else begin
            sync_reg[0] <= d;
        end
    end

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_reg[gi] <= RESET_VAL;
            end else begin
                sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit centring, LSB-first data capture, stop check with framing error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int SB_TICK    = DEF_SB_TICK
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_tick,
    input  logic                  i_rx_data,
    output logic [DATA_WIDTH-1:0] o_data_byte,
    output logic                  o_rx_done_bit,
    output logic                  o_frame_error
);

    localparam int CW = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] START_MID = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] BIT_END   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] STOP_END  = CW'(SB_TICK - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_WIDTH - 1);

    uart_state_t           state_reg, state_next;
    logic [CW-1:0]         count_reg, count_next;
    logic [IW-1:0]         index_reg, index_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] data_reg,  data_next;
    logic                  armed_reg, armed_next;
    logic                  done_reg,  done_next;
    logic                  ferr_reg,  ferr_next;
    logic                  rx_s;

    rx_sync #(
        .STAGES    (2),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (i_rx_data),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            index_reg <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            armed_reg <= 1'b0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            index_reg <= index_next;
            shift_reg <= shift_next;
            data_reg  <= data_next;
            armed_reg <= armed_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        index_next = index_reg;
        shift_next = shift_reg;
        data_next  = data_reg;
        armed_next = armed_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;

        case (state_reg)
            IDLE: begin
                // Arming on a high line keeps a continuous break from retriggering frames.
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    state_next = START;
                    count_next = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (count_reg == START_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            count_next = '0;
                            index_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (count_reg == BIT_END) begin
                        shift_next = {rx_s, shift_reg[DATA_WIDTH-1:1]};
                        count_next = '0;
                        if (index_reg == LAST_IDX) begin
                            state_next = STOP;
                        end else begin
                            index_next = index_reg + 1'b1;
                        end
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (count_reg == STOP_END) begin
                        data_next  = shift_reg;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
                        armed_next = 1'b0;
                        count_next = '0;
                        state_next = IDLE;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_data_byte   = data_reg;
    assign o_rx_done_bit = done_reg;
    assign o_frame_error = ferr_reg;

endmodule
